rgb_led_sequencer: RTL and testbench
====================================

// Module: rgb_led_sequencer
// PURPOSE
//  Table-driven controller for the board RGB LED. Holds P_STEPS colour steps {hold, r, g, b}
//  and plays them in a loop; each step shows one PWM-dimmed colour for a programmed time.
//  Sits between top-level control (buttons/host) and the three LED pins.
// PARAMETERS
//  P_STEPS     4     table depth, power of 2, >=2
//  P_PWM_BITS  8     PWM counter / duty width
//  P_HOLD_BITS 8     hold field width, in ticks
//  P_TICK_DIV  1024  clocks per tick, >=2
// PORTS
//  i_clk        in   1                          system clock
//  i_rst        in   1                          asynchronous, active-high reset
//  i_start      in   1                          pulse: start/restart at step 0
//  i_stop       in   1                          pulse: stop, LEDs off
//  i_wr_en      in   1                          table write strobe
//  i_wr_addr    in   $clog2(P_STEPS)            table entry index
//  i_wr_data    in   P_HOLD_BITS+3*P_PWM_BITS   {hold, r, g, b}, b in LSBs
//  o_wr_ready   out  1                          1 = table writes accepted (IDLE only)
//  o_busy       out  1                          1 = sequence running
//  o_step       out  $clog2(P_STEPS)            step currently shown
//  o_led_r/g/b  out  1 each                     active-low LED drive (0 = lit)
// BEHAVIOUR
//  Reset: state IDLE, table all zero, duty regs 0, counters 0, o_busy=0, o_step=0,
//   o_wr_ready=1, o_led_r/g/b=1.
//  PWM: free-running P_PWM_BITS counter, +1 every clock, wraps. o_led_x registered:
//   o_led_x <= ~(pwm_cnt < duty_x), so output lags counter by 1 cycle. duty 0 = never lit;
//   duty 2^N-1 = lit 2^N-1 of 2^N clocks. In IDLE all outputs forced 1.
//  Tick: prescaler 0..P_TICK_DIV-1 counts only in HOLD, cleared in LOAD; tick = 1-cycle pulse at wrap.
//  FSM:
//   IDLE : i_start -> LOAD, step=0.
//   LOAD : 1 cycle. duty_r/g/b <= table[step].rgb; hold_cnt <= table[step].hold -> HOLD.
//   HOLD : on tick: hold_cnt==0 -> LOAD with step=step+1 (wraps P_STEPS-1 -> 0),
//          else hold_cnt--. Step of hold h lasts (h+1)*P_TICK_DIV clocks + 1 LOAD cycle.
//  i_stop (any state): -> IDLE next cycle, step=0, duty regs 0. i_stop beats i_start same cycle.
//  i_start while busy: -> LOAD, step=0, prescaler cleared.
//  o_busy=1 in LOAD/HOLD; o_wr_ready = ~o_busy; o_step = step register.
//  Writes: table[i_wr_addr] <= i_wr_data iff i_wr_en && o_wr_ready; else dropped silently.
//   Write and i_start in same cycle: write lands, LOAD next cycle reads new data.
//  Reset asserted mid-sequence: immediate return to reset values incl. table clear.
// CONFIGURATION
//  RGB_SEQ_FADE_EN defined: in HOLD, each tick moves each duty reg 1 LSB toward
//   table[(step+1) mod P_STEPS] value (stops when equal); LOAD still loads exact values,
//   so any unfinished fade snaps at step change. Table stable in HOLD (writes blocked).
//  Not defined: duty regs change only in LOAD/IDLE (hard colour switch), no fade logic.
// TESTING (P_TICK_DIV=4, P_STEPS=4, 8-bit fields)
//  Reset: assert i_rst mid-HOLD -> LEDs=1, o_busy=0, o_step=0 asynchronously; table reads 0.
//  Write step0={hold 2,r FF,g 00,b 80}, start -> r lit 255/256, g never, b 128/256 clocks.
//  4 steps hold 0..3 -> o_step durations 5,9,13,17 clocks, wraps 3 -> 0, loops.
//  i_wr_en while busy -> table unchanged; i_start+i_stop same cycle -> IDLE, LEDs 1.
//  Duty 00 all steps -> LEDs constantly 1; i_start mid-step 2 -> o_step=0 after LOAD.
//  FADE_EN: step0 r=10 hold 7, step1 r=14 -> duty_r 11,12,13,14 over 4 ticks, then held.

Source files
------------

// File: rtl/rgb_led_sequencer.sv
// Table-driven RGB LED sequencer: loops over P_STEPS {hold, r, g, b} entries, PWM-dimming each colour.
// Optional macro RGB_SEQ_FADE_EN: duty regs step one LSB per tick toward the next entry's colour.
module rgb_led_sequencer #(
    parameter int unsigned P_STEPS     = 4,
    parameter int unsigned P_PWM_BITS  = 8,
    parameter int unsigned P_HOLD_BITS = 8,
    parameter int unsigned P_TICK_DIV  = 1024
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic                                  i_stop,
    input  logic                                  i_wr_en,
    input  logic [$clog2(P_STEPS)-1:0]            i_wr_addr,
    input  logic [P_HOLD_BITS+3*P_PWM_BITS-1:0]   i_wr_data,
    output logic                                  o_wr_ready,
    output logic                                  o_busy,
    output logic [$clog2(P_STEPS)-1:0]            o_step,
    output logic                                  o_led_r,
    output logic                                  o_led_g,
    output logic                                  o_led_b
);

    localparam int unsigned AW = $clog2(P_STEPS);
    localparam int unsigned PB = P_PWM_BITS;
    localparam int unsigned DW = P_HOLD_BITS + 3 * PB;
    localparam int unsigned PW = $clog2(P_TICK_DIV);
    localparam logic [PW-1:0] TickLast = PW'(P_TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

    state_e                 state_q, state_d;
    logic [DW-1:0]          tbl_q [P_STEPS];
    logic [AW-1:0]          step_q, step_d;
    logic [P_HOLD_BITS-1:0] hold_q, hold_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [PB-1:0]          pwm_q;
    logic [PB-1:0]          duty_r_q, duty_g_q, duty_b_q;
    logic [PB-1:0]          duty_r_d, duty_g_d, duty_b_d;
    logic                   led_r_q, led_g_q, led_b_q;
    logic                   tick, wr_ready;
    logic [DW-1:0]          cur;

    assign wr_ready = (state_q == StIdle);
    assign tick     = (state_q == StHold) && (presc_q == TickLast);
    assign cur      = tbl_q[step_q];

`ifdef RGB_SEQ_FADE_EN
    logic [3*PB-1:0] nxt_rgb;
    assign nxt_rgb = tbl_q[step_q + AW'(1)][3*PB-1:0];

    function automatic logic [PB-1:0] approach(input logic [PB-1:0] v, input logic [PB-1:0] tgt);
        if (v < tgt) return v + PB'(1);
        if (v > tgt) return v - PB'(1);
        return v;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        hold_d   = hold_q;
        presc_d  = '0;
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        // Stop wins over start; start restarts from step 0 from any state.
        if (i_stop) begin
            state_d  = StIdle;
            step_d   = '0;
            duty_r_d = '0;
            duty_g_d = '0;
            duty_b_d = '0;
        end else if (i_start) begin
            state_d = StLoad;
            step_d  = '0;
        end else begin
            case (state_q)
                StLoad: begin
                    duty_r_d = cur[3*PB-1 -: PB];
                    duty_g_d = cur[2*PB-1 -: PB];
                    duty_b_d = cur[PB-1:0];
                    hold_d   = cur[DW-1 -: P_HOLD_BITS];
                    state_d  = StHold;
                end
                StHold: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
`ifdef RGB_SEQ_FADE_EN
                        duty_r_d = approach(duty_r_q, nxt_rgb[3*PB-1 -: PB]);
                        duty_g_d = approach(duty_g_q, nxt_rgb[2*PB-1 -: PB]);
                        duty_b_d = approach(duty_b_q, nxt_rgb[PB-1:0]);
`endif
                        if (hold_q == '0) begin
                            state_d = StLoad;
                            step_d  = step_q + AW'(1);
                        end else begin
                            hold_d = hold_q - P_HOLD_BITS'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            step_q   <= '0;
            hold_q   <= '0;
            presc_q  <= '0;
            pwm_q    <= '0;
            duty_r_q <= '0;
            duty_g_q <= '0;
            duty_b_q <= '0;
            led_r_q  <= 1'b1;
            led_g_q  <= 1'b1;
            led_b_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            presc_q  <= presc_d;
            pwm_q    <= pwm_q + PB'(1);
            duty_r_q <= duty_r_d;
            duty_g_q <= duty_g_d;
            duty_b_q <= duty_b_d;
            led_r_q  <= (state_q == StIdle) ? 1'b1 : ~(pwm_q < duty_r_q);
            led_g_q  <= (state_q == StIdle) ? 1'b1 : ~(pwm_q < duty_g_q);
            led_b_q  <= (state_q == StIdle) ? 1'b1 : ~(pwm_q < duty_b_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < P_STEPS; i++) tbl_q[i] <= '0;
        end else if (i_wr_en && wr_ready) begin
            tbl_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_wr_ready = wr_ready;
    assign o_busy     = ~wr_ready;
    assign o_step     = step_q;
    assign o_led_r    = led_r_q;
    assign o_led_g    = led_g_q;
    assign o_led_b    = led_b_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Scoreboard bench for rgb_led_sequencer: stimulus queues expectations, a negedge monitor checks them.
module tb_rgb_led_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start, i_stop, i_wr_en;
    logic [1:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        o_wr_ready, o_busy;
    logic [1:0]  o_step;
    logic        o_led_r, o_led_g, o_led_b;

    rgb_led_sequencer #(
        .P_STEPS    (4),
        .P_PWM_BITS (8),
        .P_HOLD_BITS(8),
        .P_TICK_DIV (4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .o_wr_ready(o_wr_ready),
        .o_busy    (o_busy),
        .o_step    (o_step),
        .o_led_r   (o_led_r),
        .o_led_g   (o_led_g),
        .o_led_b   (o_led_b)
    );

    always #5 i_clk = ~i_clk;

    localparam int K_LEDS  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_STEP  = 2;
    localparam int K_READY = 3;
    localparam int K_CLR   = 4;
    localparam int K_LITR  = 5;
    localparam int K_LITG  = 6;
    localparam int K_LITB  = 7;
    localparam int K_DUTYR = 8;

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } item_t;

    item_t exp_q[$];
    int    dur_q[$];          // expected step segments, encoded step*1000 + clocks
    int    vectors     = 0;
    int    miscompares = 0;
    int    lit_r = 0, lit_g = 0, lit_b = 0;
    bit    dur_arm = 1'b0;
    bit    seg_on  = 1'b0;
    bit    prev_busy = 1'b0;
    int    run = 0, cur_step = 0;

    function automatic void check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    always @(negedge i_clk) begin
        item_t it;
        int    got;
        if (!o_led_r) lit_r++;
        if (!o_led_g) lit_g++;
        if (!o_led_b) lit_b++;

        if (dur_arm) begin
            if (o_busy && !prev_busy) begin
                seg_on   = 1'b1;
                run      = 1;
                cur_step = int'(o_step);
            end else if (seg_on && int'(o_step) != cur_step) begin
                if (dur_q.size() > 0) check("step_dur", cur_step * 1000 + run, dur_q.pop_front());
                cur_step = int'(o_step);
                run      = 1;
            end else if (seg_on) begin
                run++;
            end
        end else begin
            seg_on = 1'b0;
        end
        prev_busy = o_busy;

        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (it.kind == K_CLR) begin
                lit_r = 0;
                lit_g = 0;
                lit_b = 0;
            end else begin
                case (it.kind)
                    K_LEDS:  got = int'({o_led_r, o_led_g, o_led_b});
                    K_BUSY:  got = int'(o_busy);
                    K_STEP:  got = int'(o_step);
                    K_READY: got = int'(o_wr_ready);
                    K_LITR:  got = lit_r;
                    K_LITG:  got = lit_g;
                    K_LITB:  got = lit_b;
`ifdef RGB_SEQ_FADE_EN
                    K_DUTYR: got = int'(dut.duty_r_q);
`endif
                    default: got = -1;
                endcase
                check(it.name, got, it.exp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic push(input string name, input int kind, input int exp);
        item_t it;
        it.name = name;
        it.kind = kind;
        it.exp  = exp;
        exp_q.push_back(it);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic with_start);
        i_wr_en   = 1'b1;
        i_wr_addr = 2'(a);
        i_wr_data = d;
        i_start   = with_start;
        cyc(1);
        i_wr_en   = 1'b0;
        i_start   = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
    endtask

    task automatic wait_step(input int s);
        int n = 0;
        while (int'(o_step) != s && n < 200) begin
            cyc(1);
            n++;
        end
        check($sformatf("reach_step%0d", s), int'(o_step), s);
    endtask

    function automatic logic [31:0] ent(input int h, input int r, input int g, input int b);
        return {8'(h), 8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic push_lits(input string tag, input int r, input int g, input int b);
        push({tag, "_lit_r"}, K_LITR, r);
        push({tag, "_lit_g"}, K_LITG, g);
        push({tag, "_lit_b"}, K_LITB, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
        i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        cyc(1);
        push("rst_leds", K_LEDS, 7);
        push("rst_busy", K_BUSY, 0);
        push("rst_step", K_STEP, 0);
        push("rst_ready", K_READY, 1);
        cyc(1);
        i_rst = 1'b0;
        cyc(1);

        // Same colour in every step so a 256-clock window sees one full PWM period.
        for (int a = 0; a < 4; a++) wr(a, ent(2, 255, 0, 128), 1'b0);
        pulse_start();
        cyc(3);
        push("run_busy", K_BUSY, 1);
        push("run_ready", K_READY, 0);
        push("clr", K_CLR, 0);
        cyc(256);
        push_lits("pwm", 255, 0, 128);

        // Writes while busy must be dropped.
        for (int a = 0; a < 4; a++) wr(a, ent(2, 0, 255, 0), 1'b0);
        push("clr", K_CLR, 0);
        cyc(256);
        push_lits("busywr", 255, 0, 128);

        i_start = 1'b1;
        i_stop  = 1'b1;
        cyc(1);
        i_start = 1'b0;
        i_stop  = 1'b0;
        push("ss_busy", K_BUSY, 0);
        push("ss_step", K_STEP, 0);
        push("ss_ready", K_READY, 1);
        cyc(1);
        push("ss_leds", K_LEDS, 7);
        cyc(1);

        // Reset while running: asynchronous clear observed before the next clock edge.
        pulse_start();
        cyc(3);
        push("restart_busy", K_BUSY, 1);
        wait_step(1);
        i_rst = 1'b1;
        push("arst_leds", K_LEDS, 7);
        push("arst_busy", K_BUSY, 0);
        push("arst_step", K_STEP, 0);
        push("arst_ready", K_READY, 1);
        cyc(2);
        i_rst = 1'b0;
        cyc(1);

        // Table cleared by reset: every step hold 0, duty 0.
        dur_q = '{5, 1005, 2005, 3005, 5};
        dur_arm = 1'b1;
        pulse_start();
        push("clr", K_CLR, 0);
        cyc(256);
        push_lits("zero", 0, 0, 0);
        cyc(1);
        check("zero_dur_drain", dur_q.size(), 0);
        dur_arm = 1'b0;

        i_stop = 1'b1;
        cyc(1);
        i_stop = 1'b0;
        wr(0, ent(3, 255, 255, 255), 1'b0);
        for (int a = 1; a < 4; a++) wr(a, ent(a, 0, 0, 0), 1'b0);
        dur_q = '{5, 1009, 2013, 3017, 5, 1009};
        dur_arm = 1'b1;
        wr(0, ent(0, 0, 0, 0), 1'b1);   // write and start together
        push("clr", K_CLR, 0);
        cyc(256);
        push_lits("hold", 0, 0, 0);
        cyc(1);
        check("hold_dur_drain", dur_q.size(), 0);
        dur_arm = 1'b0;

        wait_step(2);
        cyc(2);
        pulse_start();
        push("rs_step_load", K_STEP, 0);
        push("rs_busy_load", K_BUSY, 1);
        cyc(1);
        push("rs_step_hold", K_STEP, 0);
        push("rs_ready_hold", K_READY, 0);
        cyc(1);

`ifdef RGB_SEQ_FADE_EN
        i_stop = 1'b1;
        cyc(1);
        i_stop = 1'b0;
        wr(0, ent(7, 10, 0, 0), 1'b0);
        wr(1, ent(0, 14, 0, 0), 1'b0);
        pulse_start();
        cyc(1);
        push("fade_r0", K_DUTYR, 10);
        for (int k = 1; k <= 6; k++) begin
            cyc(4);
            push($sformatf("fade_r%0d", k), K_DUTYR, (10 + k > 14) ? 14 : 10 + k);
        end
        cyc(1);
`endif

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
